// File: rtl/obstacle_gen_pkg.sv
// Shared types, constants and LFSR helpers for the obstacle column generator.
package obstacle_pkg;

    typedef logic [1:0] col_t;

    typedef enum logic {GAP, PIPE} state_t;

    localparam col_t        COL_EMPTY          = 2'd0;
    localparam logic [15:0] LFSR_TAPS          = 16'hB400;
    localparam logic [15:0] LFSR_SEED_FALLBACK = 16'h0001;

    function automatic logic [15:0] seed_fix(input logic [15:0] s);
        return (s == 16'd0) ? LFSR_SEED_FALLBACK : s;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/obstacle_gen_if.sv
// Column stream handshake plus control and status between generator and game datapath.
interface obstacle_gen_if;
    import obstacle_pkg::*;

    logic       start;
    logic       enable;
    logic       col_ready;
    logic       col_valid;
    col_t       col;
    logic [7:0] pipes_emitted;
    logic [3:0] gap_level;

    modport master (
        input  start, enable, col_ready,
        output col_valid, col, pipes_emitted, gap_level
    );

    modport slave (
        output start, enable, col_ready,
        input  col_valid, col, pipes_emitted, gap_level
    );

endinterface

// File: rtl/obstacle_gen_lfsr16.sv
// 16-bit right-shifting Galois LFSR with synchronous load; a zero seed becomes 1.
module lfsr16
    import obstacle_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        step,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = seed_fix(load_val);
        end else if (step) begin
            state_d = lfsr_next(state_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= seed_fix(SEED);
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/obstacle_gen.sv
// Seeded pseudo-random obstacle column generator feeding a small FIFO.
// Define OBSTACLE_GEN_RAMP_EN to shrink the base gap every 8 pipes.
module obstacle_gen
    import obstacle_pkg::*;
#(
    parameter int          MIN_GAP    = 4,
    parameter int          MAX_GAP    = 12,
    parameter int          PIPE_W     = 2,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input logic           clk,
    input logic           reset,
    obstacle_gen_if.master bus
);

    localparam int             AW      = $clog2(FIFO_DEPTH);
    localparam int             CW      = AW + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [3:0]     MAX_L   = 4'(MAX_GAP);
    localparam logic [3:0]     MIN_L   = 4'(MIN_GAP);
    localparam logic [3:0]     PW_L    = 4'(PIPE_W);
`ifdef OBSTACLE_GEN_RAMP_EN
    localparam bit             RAMP    = 1'b1;
`else
    localparam bit             RAMP    = 1'b0;
`endif

    state_t        state_q, state_d;
    logic [3:0]    gap_cnt_q, gap_cnt_d;
    logic [3:0]    pipe_cnt_q, pipe_cnt_d;
    col_t          height_q, height_d;
    logic [7:0]    pipes_q, pipes_d;
    logic [3:0]    level_q, level_d;
    col_t          mem_q [FIFO_DEPTH];
    col_t          mem_d [FIFO_DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [15:0]   lfsr;
    logic          lfsr_unused;
    logic          col_valid;
    logic          pop;
    logic          produce;
    logic          entry;
    col_t          wr_col;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (bus.start),
        .load_val (SEED),
        .step     (entry),
        .state    (lfsr)
    );

    assign lfsr_unused = ^lfsr[15:4];
    assign col_valid   = (count_q != '0);
    assign pop         = col_valid && bus.col_ready;
    assign produce     = bus.enable && ((count_q < DEPTH_C) || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= GAP;
            gap_cnt_q  <= MAX_L;
            pipe_cnt_q <= 4'd0;
            height_q   <= COL_EMPTY;
            pipes_q    <= 8'd0;
            level_q    <= MAX_L;
            mem_q      <= '{default: COL_EMPTY};
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            pipe_cnt_q <= pipe_cnt_d;
            height_q   <= height_d;
            pipes_q    <= pipes_d;
            level_q    <= level_d;
            mem_q      <= mem_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        pipe_cnt_d = pipe_cnt_q;
        height_d   = height_q;
        pipes_d    = pipes_q;
        level_d    = level_q;
        entry      = 1'b0;
        if (bus.start) begin
            state_d    = GAP;
            gap_cnt_d  = MAX_L;
            pipe_cnt_d = 4'd0;
            height_d   = COL_EMPTY;
            pipes_d    = 8'd0;
            level_d    = MAX_L;
        end else if (produce) begin
            unique case (state_q)
                GAP: begin
                    if (gap_cnt_q == 4'd1) begin
                        entry      = 1'b1;
                        state_d    = PIPE;
                        pipe_cnt_d = PW_L;
                        height_d   = (lfsr[1:0] == 2'd0) ? col_t'(2'd1) : lfsr[1:0];
                        gap_cnt_d  = level_q + 4'(lfsr[3:2]);
                        pipes_d    = pipes_q + 8'd1;
                        // New level only matters for the gap loaded at the next entry
                        if (RAMP && pipes_d[2:0] == 3'd0 && level_q > MIN_L) begin
                            level_d = level_q - 4'd1;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q - 4'd1;
                    end
                end
                PIPE: begin
                    pipe_cnt_d = pipe_cnt_q - 4'd1;
                    if (pipe_cnt_q == 4'd1) begin
                        state_d = GAP;
                    end
                end
            endcase
        end
    end

    always_comb begin
        wr_col = (state_q == PIPE) ? height_q : COL_EMPTY;
    end

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.start) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (produce) begin
                mem_d[tail_q] = wr_col;
                tail_d        = tail_q + 1'b1;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            unique case ({produce, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    assign bus.col_valid     = col_valid;
    assign bus.col           = col_valid ? mem_q[head_q] : COL_EMPTY;
    assign bus.pipes_emitted = pipes_q;
    assign bus.gap_level     = level_q;

endmodule

// File: tb/tb_obstacle_gen.sv
// Directed bench for obstacle_gen: default seed and zero-seed instances.
module tb_obstacle_gen;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    obstacle_gen_if ifa ();
    obstacle_gen_if ifz ();

    obstacle_gen dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.master)
    );

    obstacle_gen #(.SEED(16'h0000)) dut_z (
        .clk   (clk),
        .reset (reset),
        .bus   (ifz.master)
    );

    int checks = 0;
    int passes = 0;
    int got_a[$];
    int got_z[$];
    int exp_a[$];
    int exp_z[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // zeros empty columns followed by one two-column pipe of height h
    task automatic seg(input int zeros, input int h, input bit to_z);
        for (int i = 0; i < zeros; i++) begin
            if (to_z) exp_z.push_back(0);
            else      exp_a.push_back(0);
        end
        for (int i = 0; i < 2; i++) begin
            if (to_z) exp_z.push_back(h);
            else      exp_a.push_back(h);
        end
    endtask

    task automatic collect(input int na, input int nz, input int maxc);
        int cyc;
        cyc = 0;
        got_a.delete();
        got_z.delete();
        ifa.col_ready = 1'b1;
        ifz.col_ready = 1'b1;
        while ((got_a.size() < na || got_z.size() < nz) && cyc < maxc) begin
            if (ifa.col_valid && got_a.size() < na) got_a.push_back(int'(ifa.col));
            if (ifz.col_valid && got_z.size() < nz) got_z.push_back(int'(ifz.col));
            tick();
            cyc++;
        end
        check("collect_a_len", got_a.size(), na);
        check("collect_z_len", got_z.size(), nz);
    endtask

    task automatic cmp_a(input string tag);
        for (int i = 0; i < exp_a.size(); i++) begin
            check($sformatf("%s[%0d]", tag, i),
                  (i < got_a.size()) ? got_a[i] : -1, exp_a[i]);
        end
    endtask

    task automatic cmp_z(input string tag);
        for (int i = 0; i < exp_z.size(); i++) begin
            check($sformatf("%s[%0d]", tag, i),
                  (i < got_z.size()) ? got_z[i] : -1, exp_z[i]);
        end
    endtask

    initial begin
        int prev;
        int p;
        int cyc;
        int exp_lvl;

        // lfsr ACE1, E270, 7138, 389C, 1C4E
        seg(12, 1, 1'b0);
        seg(12, 1, 1'b0);
        seg(12, 1, 1'b0);
        seg(14, 1, 1'b0);
        seg(15, 2, 1'b0);
        // lfsr 0001, B400 ... 0168, 00B4, 005A
        for (int k = 0; k < 9; k++) seg(12, 1, 1'b1);
`ifdef OBSTACLE_GEN_RAMP_EN
        seg(13, 1, 1'b1);
        seg(12, 2, 1'b1);
`else
        seg(14, 1, 1'b1);
        seg(13, 2, 1'b1);
`endif

        reset = 1'b1;
        ifa.start = 1'b0; ifa.enable = 1'b0; ifa.col_ready = 1'b0;
        ifz.start = 1'b0; ifz.enable = 1'b0; ifz.col_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", ifa.col_valid, 1'b0);
        check("rst_col", ifa.col, 2'd0);
        check("rst_pipes", ifa.pipes_emitted, 8'd0);
        check("rst_level", ifa.gap_level, 4'd12);
        check("rst_z_valid", ifz.col_valid, 1'b0);

        // stall: FIFO fills, generator must hold its place
        reset = 1'b0;
        ifa.enable = 1'b1;
        ifz.enable = 1'b1;
        tick();
        check("stall_valid_c1", ifa.col_valid, 1'b1);
        check("stall_col_c1", ifa.col, 2'd0);
        repeat (9) tick();
        check("stall_valid_c10", ifa.col_valid, 1'b1);
        check("stall_pipes", ifa.pipes_emitted, 8'd0);

        collect(exp_a.size(), exp_z.size(), 400);
        cmp_a("seq_a");
        cmp_z("seq_z");
        check("z_pipes", ifz.pipes_emitted, 8'd11);

        // restart with a non-empty FIFO and a pop in the start cycle
        ifa.col_ready = 1'b0;
        ifz.enable = 1'b0;
        tick();
        tick();
        check("pre_start_valid", ifa.col_valid, 1'b1);
        ifa.col_ready = 1'b1;
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        check("start_valid", ifa.col_valid, 1'b0);
        check("start_col", ifa.col, 2'd0);
        check("start_pipes", ifa.pipes_emitted, 8'd0);
        check("start_level", ifa.gap_level, 4'd12);
        collect(exp_a.size(), 0, 400);
        cmp_a("restart_a");
        check("restart_pipes", ifa.pipes_emitted, 8'd5);

        // async reset while a pipe is being emitted
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        repeat (13) tick();
        check("pipe_col", ifa.col, 2'd1);
        check("pipe_pipes", ifa.pipes_emitted, 8'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", ifa.col_valid, 1'b0);
        check("arst_col", ifa.col, 2'd0);
        check("arst_pipes", ifa.pipes_emitted, 8'd0);
        check("arst_level", ifa.gap_level, 4'd12);
        ifa.enable = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("post_rst_valid", ifa.col_valid, 1'b0);
        ifa.enable = 1'b1;
        tick();
        check("post_rst_run_valid", ifa.col_valid, 1'b1);
        check("post_rst_run_col", ifa.col, 2'd0);

        // difficulty ramp over 72 pipes
        ifa.col_ready = 1'b1;
        prev = 0;
        cyc = 0;
        while (prev < 72 && cyc < 3000) begin
            tick();
            cyc++;
            p = int'(ifa.pipes_emitted);
            if (p != prev) begin
                prev = p;
                if (p % 8 == 0) begin
`ifdef OBSTACLE_GEN_RAMP_EN
                    exp_lvl = (12 - p / 8 < 4) ? 4 : 12 - p / 8;
`else
                    exp_lvl = 12;
`endif
                    check($sformatf("ramp_level_p%0d", p), ifa.gap_level, exp_lvl);
                end
            end
        end
        check("ramp_pipes_reached", prev, 72);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
